csr_rmw_unit: RTL and testbench
===============================

// Module: csr_rmw_unit
// PURPOSE
//  Sequential, handshaked CSR read-modify-write engine for Zicsr instructions.
//  Sits between decode/execute and the CSR file: reads the CSR, computes RW/RS/RC,
//  writes back under suppression rules, and returns the old value for rd.
//  Generalises the combinational RMW with XLEN, read latency, x0 rules and flush.
// PARAMETERS
//  XLEN    32  CSR/data width (32 or 64)
//  RD_LAT  1   cycles from csr_re to valid csr_rdata (>=1)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     reset, synchronous, active-low
//  flush        in   1     abort in-flight op (pipeline flush)
//  req_valid    in   1     request valid
//  req_ready    out  1     unit can accept (IDLE only)
//  req_addr     in   12    CSR address
//  req_funct3   in   3     instr[14:12]
//  req_rs1_idx  in   5     rs1 index / zimm
//  req_rs1_val  in   XLEN  rs1 value
//  req_rd_idx   in   5     rd index
//  csr_re       out  1     CSR file read strobe
//  csr_raddr    out  12    read address
//  csr_rdata    in   XLEN  read data, valid RD_LAT cycles after csr_re
//  csr_we       out  1     CSR file write strobe
//  csr_waddr    out  12    write address
//  csr_wdata    out  XLEN  write data
//  rsp_valid    out  1     response valid
//  rsp_ready    in   1     response accepted
//  rsp_rd_idx   out  5     destination register
//  rsp_rdata    out  XLEN  old CSR value (0 if read skipped)
//  rsp_illegal  out  1     illegal-instruction flag
// BEHAVIOUR
//  Reset: state IDLE, counter 0; req_ready=1; csr_re/csr_we/rsp_valid/rsp_illegal=0;
//   all address/data outputs 0. Reset mid-op drops the op: no write, no response.
//  FSM IDLE->READ->RWAIT(RD_LAT cycles)->WRITE->RESP->IDLE.
//   Accept on req_valid&&req_ready; all fields latched.
//  Accept at T: csr_re at T+1, rdata captured at T+1+RD_LAT, csr_we at T+2+RD_LAT,
//   rsp_valid from T+3+RD_LAT. csr_re/csr_we are single-cycle pulses.
//  Operand = funct3[2] ? {XLEN-5 zeros, rs1_idx} : rs1_val. src_zero = (rs1_idx==0).
//  RW/RWI: wdata=operand, we=1. RS/RSI: wdata=old|operand, we=~src_zero.
//   RC/RCI: wdata=old&~operand, we=~src_zero.
//  RW/RWI with rd_idx==0: READ/RWAIT skipped (IDLE->WRITE), csr_re never pulsed,
//   rsp_rdata=0.
//  funct3 000/100: IDLE->RESP with rsp_illegal=1; no csr_re, no csr_we.
//  RESP holds rsp_* stable until rsp_ready; rsp_valid&&rsp_ready -> IDLE.
//   No new accept in that cycle.
//  flush in READ/RWAIT -> IDLE next cycle: no write, no response.
//   flush in IDLE/WRITE/RESP: ignored.
//  No illegal-address checks in base build.
// CONFIGURATION
//  CSR_RMW_RO_CHECK_EN defined: req_addr[11:10]==2'b11 with a write that would fire
//   -> csr_we suppressed, rsp_illegal=1, rsp_rdata=old value.
//  Undefined: no address check; the write proceeds.
// STRUCTURE
//  csr_pkg: csr_op_t (CSR_RW..CSR_RCI), csr_rmw_state_t, CSR_ADDR_W=12.
//  Sub-module csr_rmw_alu: combinational operand select, wdata and we.
//  FSM, counter and latches live in csr_rmw_unit.
// TESTING
//  1 RD_LAT=1, CSR=0x0000_00F0, CSRRS rs1=x5 val 0x0F -> re@T+1, we@T+3 wdata=0xFF,
//    rsp@T+4 rdata=0xF0.
//  2 CSRRC rs1=x0 -> csr_we never asserts, rsp_rdata=old value.
//  3 CSRRWI rd=x0 zimm=0x1F -> csr_re never pulses, csr_wdata=0x1F, rsp_rdata=0.
//  4 funct3=000 -> rsp_illegal=1 at T+1, no re/we.
//  5 flush during RWAIT (RD_LAT=3) -> no csr_we, no rsp_valid, req_ready=1 next cycle.
//  6 rsp_ready low 5 cycles -> rsp_* stable, req_ready=0.
//    With CSR_RMW_RO_CHECK_EN, CSRRW to 0xC00 -> illegal, no we.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types for the CSR read-modify-write engine.
// Zicsr op encodings, FSM states, latched request bundle.
package csr_pkg;

  localparam int CSR_ADDR_W = 12;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RWAIT,
    ST_WRITE,
    ST_RESP
  } csr_rmw_state_t;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic [2:0]            funct3;
    logic [4:0]            rs1_idx;
    logic [4:0]            rd_idx;
  } csr_req_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational RMW datapath: operand select, new value, write enable.
// Ports: funct3/rs1_idx/rs1_val/addr/old in; wdata/we/fault out. Option: CSR_RMW_RO_CHECK_EN.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]            funct3,
  input  logic [4:0]            rs1_idx,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [CSR_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       old,
  output logic [XLEN-1:0]       wdata,
  output logic                  we,
  output logic                  fault
);

  csr_op_t         op;
  logic [XLEN-1:0] opnd;
  logic            src_zero;
  logic            we_raw;

  assign op       = csr_op_t'(funct3);
  assign opnd     = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
  assign src_zero = (rs1_idx == 5'd0);

  always_comb begin
    wdata  = opnd;
    we_raw = 1'b0;
    unique case (op)
      CSR_RW, CSR_RWI: begin
        wdata  = opnd;
        we_raw = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        wdata  = old | opnd;
        we_raw = ~src_zero;
      end
      CSR_RC, CSR_RCI: begin
        wdata  = old & ~opnd;
        we_raw = ~src_zero;
      end
      default: ;
    endcase
  end

`ifdef CSR_RMW_RO_CHECK_EN
  // addr[11:10]==11 marks read-only CSRs
  assign fault = we_raw && (addr[11:10] == 2'b11);
  assign we    = we_raw && !fault;
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign fault       = 1'b0;
  assign we          = we_raw;
`endif

endmodule

// File: rtl/csr_rmw_unit.sv
// Handshaked CSR read-modify-write engine (IDLE/READ/RWAIT/WRITE/RESP).
// Ports: req_* in, csr_* to CSR file, rsp_* out. Option: CSR_RMW_RO_CHECK_EN.
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [4:0]            req_rs1_idx,
  input  logic [XLEN-1:0]       req_rs1_val,
  input  logic [4:0]            req_rd_idx,
  output logic                  csr_re,
  output logic [CSR_ADDR_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]       csr_rdata,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd_idx,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_illegal
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  csr_rmw_state_t  state;
  csr_req_t        req_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [CNT_W-1:0] cnt;

  logic            idle;
  logic [2:0]      a_f3;
  logic [4:0]      a_rs1;
  logic [XLEN-1:0] a_val;
  logic [CSR_ADDR_W-1:0] a_addr;
  logic [XLEN-1:0] a_old;
  logic [XLEN-1:0] a_wdata;
  logic            a_we;
  logic            a_fault;

  assign idle       = (state == ST_IDLE);
  assign req_ready  = idle;
  assign csr_raddr  = req_q.addr;
  assign csr_waddr  = req_q.addr;
  assign rsp_rd_idx = req_q.rd_idx;

  // IDLE feeds the live request (rd=x0 RW jumps straight to WRITE);
  // otherwise the latched request and the arriving read data.
  assign a_f3   = idle ? req_funct3  : req_q.funct3;
  assign a_rs1  = idle ? req_rs1_idx : req_q.rs1_idx;
  assign a_val  = idle ? req_rs1_val : rs1_val_q;
  assign a_addr = idle ? req_addr    : req_q.addr;
  assign a_old  = idle ? '0          : csr_rdata;

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .funct3  (a_f3),
    .rs1_idx (a_rs1),
    .rs1_val (a_val),
    .addr    (a_addr),
    .old     (a_old),
    .wdata   (a_wdata),
    .we      (a_we),
    .fault   (a_fault)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      rs1_val_q   <= '0;
      cnt         <= '0;
      csr_re      <= 1'b0;
      csr_we      <= 1'b0;
      csr_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      csr_re <= 1'b0;
      csr_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q       <= '{req_addr, req_funct3, req_rs1_idx, req_rd_idx};
            rs1_val_q   <= req_rs1_val;
            cnt         <= '0;
            rsp_rdata   <= '0;
            rsp_illegal <= 1'b0;
            unique case (1'b1)
              !f3_legal(req_funct3): begin
                state       <= ST_RESP;
                rsp_valid   <= 1'b1;
                rsp_illegal <= 1'b1;
              end
              req_funct3[1:0] == 2'b01 && req_rd_idx == 5'd0: begin
                state       <= ST_WRITE;
                csr_we      <= a_we;
                csr_wdata   <= a_wdata;
                rsp_illegal <= a_fault;
              end
              default: begin
                state  <= ST_READ;
                csr_re <= 1'b1;
              end
            endcase
          end
        end
        ST_READ: begin
          state <= flush ? ST_IDLE : ST_RWAIT;
        end
        ST_RWAIT: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_W'(RD_LAT - 1)) begin
            state       <= ST_WRITE;
            rsp_rdata   <= csr_rdata;
            csr_we      <= a_we;
            csr_wdata   <= a_wdata;
            rsp_illegal <= a_fault;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Randomised bench for csr_rmw_unit against a behavioural CSR model.
// Includes a CSR file with fixed read latency that returns junk outside it.
module tb_csr_rmw_unit;

  localparam int XLEN = 32;
  localparam int LAT  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [11:0]     req_addr = '0;
  logic [2:0]      req_funct3 = '0;
  logic [4:0]      req_rs1_idx = '0;
  logic [XLEN-1:0] req_rs1_val = '0;
  logic [4:0]      req_rd_idx = '0;
  logic            csr_re;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [4:0]      rsp_rd_idx;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_rmw_unit #(.XLEN(XLEN), .RD_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_funct3  (req_funct3),
    .req_rs1_idx (req_rs1_idx),
    .req_rs1_val (req_rs1_val),
    .req_rd_idx  (req_rd_idx),
    .csr_re      (csr_re),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_we      (csr_we),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rd_idx  (rsp_rd_idx),
    .rsp_rdata   (rsp_rdata),
    .rsp_illegal (rsp_illegal)
  );

  function automatic logic [XLEN-1:0] seed(input int i);
    return XLEN'((i * 32'h0101_0101) ^ 32'h5A5A_0000);
  endfunction

  // CSR file: data valid exactly LAT cycles after the read strobe
  logic [XLEN-1:0] mem [4096];
  logic [LAT-1:0]  vpipe;
  logic [11:0]     apipe [LAT];
  logic [XLEN-1:0] junk;

  assign csr_rdata = vpipe[LAT-1] ? mem[apipe[LAT-1]] : junk;

  always @(posedge clk) begin
    junk <= XLEN'($urandom());
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed(i);
      vpipe <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vpipe[i] <= vpipe[i-1];
        apipe[i] <= apipe[i-1];
      end
      vpipe[0] <= csr_re;
      apipe[0] <= csr_raddr;
      if (csr_we) mem[csr_waddr] <= csr_wdata;
    end
  end

  logic [XLEN-1:0] refm [4096];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [11:0] a, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [XLEN-1:0] v,
                        input logic [4:0] rd, input int stall, input int fk);
    logic legal, skip, reads, ill, wr, abort;
    logic [XLEN-1:0] opnd, old, nv, wd, r_data;
    logic [11:0] wa;
    logic r_ill;
    logic [4:0] r_rd;
    int exp_wek, exp_rspk;
    int re_n, re_k, we_n, we_k, rsp_k, k;

    legal = (f3[1:0] != 2'b00);
    skip  = legal && f3[1:0] == 2'b01 && rd == 5'd0;
    reads = legal && !skip;
    ill   = !legal;
    opnd  = f3[2] ? XLEN'(rs1) : v;
    old   = reads ? refm[a] : '0;
    case (f3[1:0])
      2'b01:   nv = opnd;
      2'b10:   nv = old | opnd;
      default: nv = old & ~opnd;
    endcase
    wr = legal && (f3[1:0] == 2'b01 || rs1 != 5'd0);
`ifdef CSR_RMW_RO_CHECK_EN
    if (wr && a[11:10] == 2'b11) begin
      wr  = 1'b0;
      ill = 1'b1;
    end
`endif
    abort    = reads && fk >= 1 && fk <= 1 + LAT;
    exp_wek  = skip ? 1 : 2 + LAT;
    exp_rspk = !legal ? 1 : (skip ? 2 : 3 + LAT);

    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr = a; req_funct3 = f3; req_rs1_idx = rs1;
    req_rs1_val = v; req_rd_idx = rd;
    re_n = 0; re_k = 0; we_n = 0; we_k = 0; rsp_k = 0; k = 0;
    wd = '0; wa = '0; r_data = '0; r_ill = 1'b0; r_rd = '0;

    while (k < 40 && rsp_k == 0 && !(abort && k >= fk + LAT + 4)) begin
      k++;
      @(negedge clk);
      req_valid = 1'b0;
      flush = (k == fk);
      if (csr_re) begin re_n++; re_k = k; end
      if (csr_we) begin we_n++; we_k = k; wd = csr_wdata; wa = csr_waddr; end
      if (abort && k == fk + 1) chk("flush_ready", req_ready, 1);
      if (rsp_valid) begin
        rsp_k = k; r_data = rsp_rdata; r_ill = rsp_illegal; r_rd = rsp_rd_idx;
      end
    end

    chk("re_count", re_n, reads ? 1 : 0);
    if (reads) chk("re_cycle", re_k, 1);

    if (abort) begin
      flush = 1'b0;
      chk("abort_no_we", we_n, 0);
      chk("abort_no_rsp", rsp_k, 0);
    end else begin
      chk("rsp_cycle", rsp_k, exp_rspk);
      chk("we_count", we_n, wr ? 1 : 0);
      if (wr) begin
        chk("we_cycle", we_k, exp_wek);
        chk("wdata", wd, nv);
        chk("waddr", wa, a);
      end
      chk("rsp_rdata", r_data, old);
      chk("rsp_illegal", r_ill, ill);
      chk("rsp_rd", r_rd, rd);
      if (rsp_k != 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          flush = 1'b0;
          chk("hold_valid", {rsp_valid, req_ready}, 2'b10);
          chk("hold_rdata", rsp_rdata, r_data);
          chk("hold_ctl", {rsp_illegal, rsp_rd_idx}, {r_ill, r_rd});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        flush = 1'b0;
        chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
      end
      if (wr) refm[a] = nv;
    end
    chk("csr_val", mem[a], refm[a]);
  endtask

  logic [11:0] addrs [8];

  initial begin
    addrs = '{12'h300, 12'h305, 12'h340, 12'h7C0,
              12'hC00, 12'hB00, 12'h001, 12'h800};
    for (int i = 0; i < 4096; i++) refm[i] = seed(i);

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {csr_re, csr_we, rsp_valid, rsp_illegal}, 4'b0);
    chk("rst_addr", {csr_raddr, csr_waddr, rsp_rd_idx}, '0);
    chk("rst_data", {csr_wdata, rsp_rdata}, '0);
    rst_n = 1'b1;

    // preload 0x340 = 0xF0 via CSRRW rd=x0
    run_op(12'h340, 3'b001, 5'd1, 32'h0000_00F0, 5'd0, 0, 0);
    // CSRRS x5=0x0F -> 0xFF, old 0xF0
    run_op(12'h340, 3'b010, 5'd5, 32'h0000_000F, 5'd3, 0, 0);
    // CSRRC rs1=x0: no write
    run_op(12'h340, 3'b011, 5'd0, 32'hFFFF_FFFF, 5'd4, 0, 0);
    // CSRRWI rd=x0 zimm=0x1F
    run_op(12'h340, 3'b101, 5'h1F, 32'h0, 5'd0, 0, 0);
    // illegal funct3 000 and 100
    run_op(12'h340, 3'b000, 5'd7, 32'h1234, 5'd2, 0, 0);
    run_op(12'h305, 3'b100, 5'd7, 32'h1234, 5'd2, 1, 0);
    // flush in READ and in RWAIT
    run_op(12'h300, 3'b010, 5'd2, 32'hFFFF_0000, 5'd6, 0, 2);
    run_op(12'h300, 3'b011, 5'd2, 32'h0000_FFFF, 5'd6, 0, 1);
    // flush in WRITE and RESP ignored
    run_op(12'h300, 3'b001, 5'd9, 32'hA5A5_5A5A, 5'd6, 0, 2 + LAT);
    run_op(12'h300, 3'b110, 5'd9, 32'h0, 5'd6, 2, 3 + LAT);
    // response back-pressure
    run_op(12'h7C0, 3'b011, 5'd8, 32'h0F0F_0F0F, 5'd1, 5, 0);
    // read-only range
    run_op(12'hC00, 3'b001, 5'd3, 32'hDEAD_0001, 5'd1, 0, 0);
    run_op(12'hC00, 3'b010, 5'd0, 32'hDEAD_0001, 5'd1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [11:0] a;
      logic [4:0] rs1, rd;
      int fk;
      a   = addrs[$urandom_range(0, 7)];
      rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
      fk  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3 + LAT) : 0;
      run_op(a, 3'($urandom()), rs1, XLEN'($urandom()), rd,
             $urandom_range(0, 3), fk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
